// File: rtl/kmap_scanner.sv
// Exhaustive truth-table capture for a 4-input combinational function stage:
// sweeps every x code, samples f after DWELL cycles, commits table and popcount.
module kmap_scanner #(
   parameter int unsigned DWELL = 1,
   parameter bit          GRAY  = 1'b0
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        start_i,
   output logic [4:1]  x_o,
   input  logic        f_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [15:0] table_o,
   output logic [4:0]  ones_count_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

   state_t      state_q;
   logic [3:0]  step_q;
   logic [3:0]  dwell_q;
   logic [3:0]  x_q;
   logic [15:0] shadow_q;
   logic [15:0] table_q;
   logic [4:0]  ones_q;
   logic        busy_q;
   logic        done_q;

   logic [3:0]  step_d;
   logic [3:0]  code_d;
   logic        sample_edge;
   logic [15:0] shadow_d;
   logic [4:0]  ones_d;

   // shadow_d already carries the bit sampled on this edge, so the commit on
   // the final step includes it without an extra cycle.
   always_comb begin
      step_d      = step_q + 4'd1;
      code_d      = GRAY ? (step_d ^ (step_d >> 1)) : step_d;
      sample_edge = (dwell_q == DWELL_LAST);
      shadow_d    = shadow_q;
      shadow_d[x_q] = f_i;
      ones_d      = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         ones_d = ones_d + 5'(shadow_d[i]);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         state_q  <= S_IDLE;
         step_q   <= '0;
         dwell_q  <= '0;
         x_q      <= '0;
         shadow_q <= '0;
         table_q  <= '0;
         ones_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  state_q  <= S_SCAN;
                  busy_q   <= 1'b1;
                  step_q   <= '0;
                  dwell_q  <= '0;
                  shadow_q <= '0;
                  x_q      <= '0;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_SCAN: begin
               if (sample_edge) begin
                  shadow_q <= shadow_d;
                  dwell_q  <= '0;
                  if (step_q == 4'd15) begin
                     state_q <= S_DONE;
                     table_q <= shadow_d;
                     ones_q  <= ones_d;
                     x_q     <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     step_q <= step_d;
                     x_q    <= code_d;
                  end
               end else begin
                  dwell_q <= dwell_q + 4'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign x_o          = x_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign table_o      = table_q;
   assign ones_count_o = ones_q;

endmodule

// File: doc/kmap_scanner.md
# kmap_scanner

Exhaustive truth-table capture stage for a 4-input combinational function block. On request, drives every code of `x[4:1]` into the function under test, samples its single-bit `f` output after a programmable settle time, and publishes the 16-entry truth table with a popcount. It sits directly around the combinational K-map function stage: `x` feeds that stage's input, and its `f` returns here. It is used for self-check and readback of the implemented function.

## Interface
- `DWELL`, default 1: cycles each code is held on `x`. Legal range is 1..15. `f` is sampled on the last cycle of the dwell.
- `GRAY`, default 0: sweep order. 0 gives binary 0,1,...,15. 1 gives Gray order, where step i drives i ^ (i>>1).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  scan request. Accepted only when `busy`=0.
- `x`  out  4 (`[4:1]`)  code driven to the function stage. Registered.
- `f`  in  1  function result for the current `x`.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  one-cycle pulse marking the commit of a new table.
- `table`  out  16  committed truth table; bit k = f(x=k).
- `ones_count`  out  5  popcount of `table`, range 0..16.

## Operation
- States:
  - IDLE: `busy`=0.
  - SCAN: `busy`=1.
  - DONE: `busy`=0, `done`=1, lasts one cycle, then IDLE.
- IDLE → SCAN when `start`=1 is sampled.
  - Step counter and dwell counter clear to 0.
  - Shadow table clears to 0.
  - `x` loads the first code, which is 0 in both orders.
- SCAN behaviour:
  - Dwell counter counts 0..DWELL-1.
  - On the edge ending dwell count DWELL-1, `shadow[x] <= f`. The shadow is indexed by the code value, not the step number.
  - The step then increments, and `x` loads the next code.
- After step 15 is sampled, go to SCAN → DONE.
  - `table <= shadow`, including the bit sampled on that same edge.
  - `ones_count <= popcount`.
  - `x` returns to 0.
- `table` and `ones_count` change only on the commit edge. They hold their last values through later scans until the next commit.
- `start` while `busy`=1 is ignored; it is not queued.
- `start` sampled in the DONE cycle is accepted. DONE → SCAN then follows directly, with `done` still pulsing for that one cycle.
- `resetn`=0 sampled on any edge, including mid-scan:
  - state → IDLE; `x`=0, `busy`=0, `done`=0, `table`=0, `ones_count`=0.
  - Shadow and counters clear; the partial scan is discarded.
- `f` is ignored outside sample edges; X on `f` in IDLE must not propagate.

## Timing
- Reset values: `x`=4'h0, `busy`=0, `done`=0, `table`=16'h0000, `ones_count`=5'd0.
- `start` high at edge E0 gives:
  - `busy`=1 from E0 until E0+16·DWELL.
  - Code n is on `x` from edge E0+n·DWELL for DWELL cycles.
  - `f` for code n is sampled at edge E0+(n+1)·DWELL.
  - `done`=1, new `table` and `ones_count` are visible in the cycle after edge E0+16·DWELL.
- Latency from start edge to done is 16·DWELL+1 edges. DWELL=1 gives 17; DWELL=3 gives 49.
- Back-to-back scans, with `start` held in the DONE cycle, have a period of 16·DWELL+1 cycles.
- The function stage is combinational. DWELL=1 requires `f` to settle within one cycle of `x`.

## Test plan
- Reset, then hold `resetn`=1 with `start`=0 for 5 cycles.
  - Required: `x`=0, `busy`=0, `done`=0, `table`=16'h0000, `ones_count`=0 throughout.
- Connect the K-map stage with ones at x = 0,1,4,5,6,12,14,15. Set DWELL=1, GRAY=0, pulse `start`.
  - Required: `done` exactly 17 edges later.
  - Required: `table`=16'hD073, `ones_count`=8.
  - Required: `x` sequence 0..15, one per cycle.
- Same function with GRAY=1, DWELL=3.
  - Required: `x` sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, each held 3 cycles.
  - Required: `done` after 49 edges; `table`=16'hD073.
- `f` tied to 1, then a second scan with `f` tied to 0; during the second scan assert `start` again.
  - Required: first scan gives `table`=16'hFFFF, `ones_count`=16.
  - Required: the extra `start` is ignored; `table` stays 16'hFFFF until the second commit.
  - Required: second scan gives `table`=16'h0000, `ones_count`=0.
- Assert `resetn`=0 for one edge at step 7 of a scan.
  - Required: `busy`=0, `x`=0, `table`=0 next cycle.
  - Required: no `done` pulse.
  - Required: a fresh `start` completes normally.
- Hold `start`=1 continuously.
  - Required: `done` pulses every 17 cycles (DWELL=1).
  - Required: `busy` is low only in DONE cycles after the first.
